// File: rtl/hsst_refclk_pkg.sv
// hsst_refclk_pkg: state encoding and default timing for the refclk power-up monitor
package hsst_refclk_pkg;
  typedef enum logic [1:0] {
    ST_PWRDN   = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;
  localparam int unsigned DEF_PWRDN_CYCLES  = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 4096;
  localparam int unsigned DEF_WINDOW_CYCLES = 65536;
  localparam int unsigned DEF_EXP_EDGES     = 1600;
  localparam int unsigned DEF_TOL_EDGES     = 16;
  localparam int unsigned DEF_LOCK_WINDOWS  = 4;
  localparam int          DEF_CNT_W         = 16;
endpackage

// File: rtl/hsst_refclk_edge_sync.sv
// hsst_refclk_edge_sync: 2-FF synchronizer plus registered rising-edge pulse
module hsst_refclk_edge_sync
  import hsst_refclk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, rise_q, rise_d;
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/hsst_refclk_pwrup_monitor.sv
// hsst_refclk_pwrup_monitor: powers up the refclk buffer, then qualifies the
// divided refclk by counting its edges per free-clock window before flagging ok.
module hsst_refclk_pwrup_monitor
  import hsst_refclk_pkg::*;
#(
  parameter int unsigned PWRDN_CYCLES  = DEF_PWRDN_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned EXP_EDGES     = DEF_EXP_EDGES,
  parameter int unsigned TOL_EDGES     = DEF_TOL_EDGES,
  parameter int unsigned LOCK_WINDOWS  = DEF_LOCK_WINDOWS,
  parameter int          CNT_W         = DEF_CNT_W
) (
  input  logic             i_free_clk,
  input  logic             i_rst,
  input  logic             i_pwrdn_req,
  input  logic             i_refclk_div,
  output logic             o_com_powerdown,
  output logic             o_refclk_ok,
  output logic             o_refclk_lost,
  output logic [CNT_W-1:0] o_edge_count,
  output logic [1:0]       o_state
);
  localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'(EXP_EDGES - TOL_EDGES);
  localparam logic [CNT_W-1:0] GOOD_HI = CNT_W'(EXP_EDGES + TOL_EDGES);
  state_t           state_q, state_d;
  logic [31:0]      cyc_q, cyc_d, run_q, run_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d, edge_count_q, edge_count_d, win_cnt;
  logic             com_pd_q, com_pd_d, ok_q, ok_d, lost_q, lost_d;
  logic             rise, measuring, win_end, good;
  hsst_refclk_edge_sync u_sync (
    .clk (i_free_clk),
    .rst (i_rst),
    .d   (i_refclk_div),
    .rise(rise)
  );
  // cyc_q is shared: power-down hold, settle wait and measurement window
  assign measuring = state_q == ST_MEASURE || state_q == ST_LOCKED;
  assign win_end   = measuring && cyc_q == WINDOW_CYCLES - 1;
  assign win_cnt   = &ecnt_q ? ecnt_q : ecnt_q + CNT_W'(rise);
  assign good      = win_cnt != '0 && win_cnt >= GOOD_LO && win_cnt <= GOOD_HI;
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    ecnt_d       = '0;
    run_d        = run_q;
    edge_count_d = edge_count_q;
    lost_d       = lost_q;
    if (state_q == ST_PWRDN) begin
      state_d = cyc_q == PWRDN_CYCLES - 1 ? ST_SETTLE : ST_PWRDN;
      cyc_d   = cyc_q == PWRDN_CYCLES - 1 ? '0 : cyc_q + 32'd1;
    end else if (state_q == ST_SETTLE) begin
      state_d = cyc_q == SETTLE_CYCLES - 1 ? ST_MEASURE : ST_SETTLE;
      cyc_d   = cyc_q == SETTLE_CYCLES - 1 ? '0 : cyc_q + 32'd1;
    end else begin
      cyc_d        = win_end ? '0 : cyc_q + 32'd1;
      ecnt_d       = win_end ? '0 : win_cnt;
      edge_count_d = win_end ? win_cnt : edge_count_q;
      if (win_end && good && state_q == ST_MEASURE) begin
        run_d   = run_q + 32'd1;
        state_d = run_q + 32'd1 == LOCK_WINDOWS ? ST_LOCKED : ST_MEASURE;
      end
      if (win_end && !good) begin
        run_d   = '0;
        state_d = ST_MEASURE;
        lost_d  = lost_q | (state_q == ST_LOCKED);
      end
    end
    if (i_pwrdn_req) begin
      state_d = ST_PWRDN;
      cyc_d   = '0;
      ecnt_d  = '0;
      run_d   = '0;
      lost_d  = 1'b0;
    end
    com_pd_d = state_d == ST_PWRDN;
    ok_d     = state_d == ST_LOCKED;
  end
  always_ff @(posedge i_free_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_PWRDN;
      cyc_q        <= '0;
      ecnt_q       <= '0;
      run_q        <= '0;
      edge_count_q <= '0;
      com_pd_q     <= 1'b1;
      ok_q         <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      ecnt_q       <= ecnt_d;
      run_q        <= run_d;
      edge_count_q <= edge_count_d;
      com_pd_q     <= com_pd_d;
      ok_q         <= ok_d;
      lost_q       <= lost_d;
    end
  end
  assign o_com_powerdown = com_pd_q;
  assign o_refclk_ok     = ok_q;
  assign o_refclk_lost   = lost_q;
  assign o_edge_count    = edge_count_q;
  assign o_state         = state_q;
endmodule

// File: tb/tb_hsst_refclk_pwrup_monitor.sv
// tb_hsst_refclk_pwrup_monitor: vector table, hand sequences and random stimulus
// against a window-by-window reference model built from edge timestamps.
module tb_hsst_refclk_pwrup_monitor;
  localparam int PWR = 8, SET = 16, WIN = 256, EXP = 16, TOL = 2, LOCK = 2, CW = 16;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rc = 1'b0;
  logic pd, ok, lost;
  logic [CW-1:0] ec;
  logic [1:0] st;
  int n_cmp = 0, n_bad = 0, cyc = 0, per = 0, ph = 0;
  int m_st, m_t, m_run, m_ec;
  bit m_lost, m_last;
  int arr[$];
  typedef struct {
    int per; bit req; int n; logic [1:0] st; bit pd; bit ok; bit lost; int lo; int hi;
  } vec_t;
  vec_t tbl[12];
  int pers[8] = '{0, 12, 14, 15, 16, 17, 18, 20};
  always #5 clk = ~clk;
  hsst_refclk_pwrup_monitor #(
    .PWRDN_CYCLES(PWR), .SETTLE_CYCLES(SET), .WINDOW_CYCLES(WIN),
    .EXP_EDGES(EXP), .TOL_EDGES(TOL), .LOCK_WINDOWS(LOCK), .CNT_W(CW)
  ) dut (
    .i_free_clk(clk), .i_rst(rst), .i_pwrdn_req(req), .i_refclk_div(rc),
    .o_com_powerdown(pd), .o_refclk_ok(ok), .o_refclk_lost(lost),
    .o_edge_count(ec), .o_state(st)
  );
  task automatic model_reset();
    m_st = 0; m_t = 0; m_run = 0; m_ec = 0; m_lost = 1'b0; m_last = 1'b0;
    arr.delete();
  endtask
  // edges become visible to the counter three clocks after being sampled
  task automatic model_edge(input bit r, input bit s);
    int n;
    bit we, good;
    if (s && !m_last) arr.push_back(cyc + 3);
    m_last = s;
    while (arr.size() > 0 && arr[0] <= cyc - WIN) void'(arr.pop_front());
    n = 0;
    foreach (arr[i]) if (arr[i] <= cyc) n++;
    we = m_st >= 2 && m_t == WIN - 1;
    good = n >= EXP - TOL && n <= EXP + TOL && n > 0;
    if (we) m_ec = n;
    if (r) begin
      m_st = 0; m_t = 0; m_run = 0; m_lost = 1'b0;
    end else if (m_st == 0) begin
      if (m_t == PWR - 1) begin m_st = 1; m_t = 0; end else m_t++;
    end else if (m_st == 1) begin
      if (m_t == SET - 1) begin m_st = 2; m_t = 0; end else m_t++;
    end else if (!we) begin
      m_t++;
    end else begin
      m_t = 0;
      if (!good) begin
        if (m_st == 3) m_lost = 1'b1;
        m_st = 2; m_run = 0;
      end else if (m_st == 2) begin
        m_run++;
        if (m_run == LOCK) m_st = 3;
      end
    end
  endtask
  task automatic check_model();
    n_cmp++;
    if (pd !== (m_st == 0) || ok !== (m_st == 3) || lost !== m_lost || ec !== CW'(m_ec) || st !== 2'(m_st)) begin
      n_bad++;
      $display("FAIL model cyc=%0d got st=%0d pd=%b ok=%b lost=%b ec=%0d want st=%0d pd=%b ok=%b lost=%b ec=%0d",
               cyc, st, pd, ok, lost, ec, m_st, m_st == 0, m_st == 3, m_lost, m_ec);
    end
  endtask
  task automatic check_reset(input string tag);
    n_cmp++;
    if (pd !== 1'b1 || ok !== 1'b0 || lost !== 1'b0 || ec !== '0 || st !== 2'd0) begin
      n_bad++;
      $display("FAIL %s got st=%0d pd=%b ok=%b lost=%b ec=%0d want st=0 pd=1 ok=0 lost=0 ec=0", tag, st, pd, ok, lost, ec);
    end
  endtask
  task automatic tick();
    rc = per > 0 && (ph % (per > 0 ? per : 1)) < per / 2;
    ph++;
    @(posedge clk);
    cyc++;
    model_edge(req, rc);
    #1 check_model();
  endtask
  initial begin
    int k;
    tbl[0]  = '{16, 1'b0, 7,   2'd0, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{16, 1'b0, 1,   2'd1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{16, 1'b0, 527, 2'd2, 1'b0, 1'b0, 1'b0, 15, 17};
    tbl[3]  = '{16, 1'b0, 1,   2'd3, 1'b0, 1'b1, 1'b0, 15, 17};
    tbl[4]  = '{0,  1'b0, 256, 2'd2, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[5]  = '{0,  1'b0, 256, 2'd2, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[6]  = '{15, 1'b0, 512, 2'd3, 1'b0, 1'b1, 1'b1, 16, 18};
    tbl[7]  = '{15, 1'b1, 5,   2'd0, 1'b1, 1'b0, 1'b0, 16, 18};
    tbl[8]  = '{15, 1'b0, 7,   2'd0, 1'b1, 1'b0, 1'b0, 16, 18};
    tbl[9]  = '{15, 1'b0, 1,   2'd1, 1'b0, 1'b0, 1'b0, 16, 18};
    tbl[10] = '{12, 1'b0, 528, 2'd2, 1'b0, 1'b0, 1'b0, 20, 22};
    tbl[11] = '{12, 1'b0, 256, 2'd2, 1'b0, 1'b0, 1'b0, 20, 22};
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset("reset_initial");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].per != per) begin per = tbl[i].per; ph = 0; end
      req = tbl[i].req;
      repeat (tbl[i].n) tick();
      n_cmp++;
      if (st !== tbl[i].st || pd !== tbl[i].pd || ok !== tbl[i].ok || lost !== tbl[i].lost ||
          int'(ec) < tbl[i].lo || int'(ec) > tbl[i].hi) begin
        n_bad++;
        $display("FAIL vec%0d got st=%0d pd=%b ok=%b lost=%b ec=%0d want st=%0d pd=%b ok=%b lost=%b ec=%0d..%0d",
                 i, st, pd, ok, lost, ec, tbl[i].st, tbl[i].pd, tbl[i].ok, tbl[i].lost, tbl[i].lo, tbl[i].hi);
      end
    end
    // asynchronous reset in MEASURE, then the full power-up sequence again
    per = 16; ph = 0; req = 1'b0;
    repeat (100) tick();
    #2 rst = 1'b1;
    #1 check_reset("reset_async");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    while (ok !== 1'b1 && k < 700) begin tick(); k++; end
    n_cmp++;
    if (k != PWR + SET + LOCK * WIN) begin
      n_bad++;
      $display("FAIL relock_latency got %0d cycles want %0d", k, PWR + SET + LOCK * WIN);
    end
    for (int s = 0; s < 40; s++) begin
      per = pers[$urandom_range(0, 7)];
      ph = $urandom_range(0, 19);
      if ($urandom_range(0, 4) == 0) begin
        req = 1'b1;
        repeat ($urandom_range(1, 10)) tick();
        req = 1'b0;
      end
      repeat ($urandom_range(200, 800)) tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hsst_refclk_pwrup_monitor.md
Name: hsst_refclk_pwrup_monitor

Overview:
Sequences the HSSTHP reference-clock buffer out of power-down, then qualifies the buffered refclk before the HPLL reset sequencer is released. It drives the buffer's COM_POWERDOWN input and measures the refclk frequency as seen by fabric. The measurement uses an externally divided copy of the fabric refclk, counted against the free-running fabric clock. It asserts a refclk-good flag downstream and flags loss of refclk.

Parameters:
PWRDN_CYCLES, 1024, free-clock cycles COM_POWERDOWN is held after reset or i_pwrdn_req drop
SETTLE_CYCLES, 4096, free-clock cycles waited after power-up before measuring
WINDOW_CYCLES, 65536, measurement window length in free-clock cycles
EXP_EDGES, 1600, expected i_refclk_div rising edges per window (156.25 MHz/64 vs 100 MHz free clock)
TOL_EDGES, 16, allowed absolute deviation from EXP_EDGES
LOCK_WINDOWS, 4, consecutive good windows required to assert o_refclk_ok
CNT_W, 16, edge-counter width

Ports:
i_free_clk  in  1  free-running fabric clock; sole clock
i_rst  in  1  asynchronous, active-high reset
i_pwrdn_req  in  1  request to power down refclk buffer (level)
i_refclk_div  in  1  divided fabric refclk, async to i_free_clk, freq < i_free_clk/4
o_com_powerdown  out  1  to buffer COM_POWERDOWN; 1 = powered down
o_refclk_ok  out  1  refclk qualified; enables downstream HPLL sequencing
o_refclk_lost  out  1  sticky: refclk failed a window while locked
o_edge_count  out  CNT_W  edge count of last completed window
o_state  out  2  current FSM state (debug)

Behaviour:
- Reset values: o_com_powerdown=1, o_refclk_ok=0, o_refclk_lost=0, o_edge_count=0, o_state=PWRDN; sync flops 0; all counters 0.
- Input path: 2-FF synchronizer plus edge register; a rising edge of i_refclk_div is counted 3 free-clock cycles after it is sampled.
- States: PWRDN=0, SETTLE=1, MEASURE=2, LOCKED=3. All outputs are registered.
- PWRDN: o_com_powerdown=1. The counter holds at 0 while i_pwrdn_req=1. Otherwise it counts up; at PWRDN_CYCLES it moves to SETTLE and o_com_powerdown goes to 0 on that edge.
- SETTLE: after SETTLE_CYCLES cycles, go to MEASURE with the window counter and edge counter cleared.
- Window: the window counter wraps at WINDOW_CYCLES-1. In the wrap cycle, the edge count (including an edge arriving that cycle) is latched to o_edge_count and the counter is cleared. Edges in the following cycle belong to the new window. The edge counter saturates at 2^CNT_W-1.
- Good window: EXP_EDGES-TOL_EDGES <= count <= EXP_EDGES+TOL_EDGES. Zero edges counts as bad.
- MEASURE: a good window increments the good-run counter and a bad window clears it. When the run reaches LOCK_WINDOWS, go to LOCKED and set o_refclk_ok=1 on the same edge.
- LOCKED: measurement continues. A bad window means next state MEASURE, o_refclk_ok=0, o_refclk_lost=1, and the good-run counter cleared.
- o_refclk_lost stays set until i_rst or i_pwrdn_req.
- i_pwrdn_req=1 in any state: next edge goes to PWRDN with o_com_powerdown=1, o_refclk_ok=0, o_refclk_lost=0, and all counters cleared. o_edge_count is held.
- Simultaneous window end and i_pwrdn_req: i_pwrdn_req wins, but o_edge_count still updates.
- Asynchronous reset mid-operation forces reset values immediately.

Decomposition:
- Package hsst_refclk_pkg: state encoding constants (ST_PWRDN, ST_SETTLE, ST_MEASURE, ST_LOCKED) and default parameter values.
- One sub-module, hsst_refclk_edge_sync: 2-FF synchronizer plus rising-edge pulse generator.

Test Plan:
(Bench parameters: PWRDN_CYCLES=8, SETTLE_CYCLES=16, WINDOW_CYCLES=256, EXP_EDGES=16, TOL_EDGES=2, LOCK_WINDOWS=2.)
- Release reset; i_refclk_div period 16 cycles -> o_com_powerdown=1 for exactly 8 cycles then 0. o_refclk_ok rises 16+512 cycles later. o_edge_count=16 (±1).
- i_refclk_div held 0 -> o_edge_count=0 each window, o_state stays MEASURE, o_refclk_ok never 1.
- Period 12 cycles (about 21 edges) -> every window bad, never locks. Period 15 (about 17 edges) -> locks.
- Stop i_refclk_div while LOCKED -> at that window end o_refclk_ok=0, o_refclk_lost=1, o_state=MEASURE. Restart it -> o_refclk_ok returns after 2 good windows while o_refclk_lost stays 1.
- Pulse i_pwrdn_req 5 cycles in LOCKED -> next edge o_com_powerdown=1, o_refclk_ok=0, o_refclk_lost=0. Powerdown persists 8 cycles after the request drops.
- Assert i_rst mid-MEASURE -> outputs take reset values without waiting for a clock edge. The full sequence repeats after release.
